// File: rtl/st_port_arbiter.sv
// Round-robin arbiter sharing the data-cache store port among NR_PORTS requesters.
// A selection that the cache does not grant immediately is locked until granted or killed.
module st_port_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int PLEN     = 56,
    parameter int XLEN     = 64,
    parameter int SEL_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       stall_i,
    input  logic [NR_PORTS-1:0]        req_i,
    input  logic [NR_PORTS*PLEN-1:0]   addr_i,
    input  logic [NR_PORTS*XLEN-1:0]   wdata_i,
    input  logic [NR_PORTS*XLEN/8-1:0] be_i,
    input  logic [NR_PORTS*2-1:0]      size_i,
    output logic [NR_PORTS-1:0]        gnt_o,
    output logic                       cache_req_o,
    output logic [PLEN-1:0]            cache_addr_o,
    output logic [XLEN-1:0]            cache_wdata_o,
    output logic [XLEN/8-1:0]          cache_be_o,
    output logic [1:0]                 cache_size_o,
    input  logic                       cache_gnt_i,
    output logic [SEL_W-1:0]           sel_o,
    output logic                       busy_o,
    output logic                       idle_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_q, rr_d;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] cur_sel;
    logic             sel_req;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] x);
        if (int'(x) >= NR_PORTS - 1)
            return '0;
        return x + SEL_W'(1);
    endfunction

    // First requester at or above rr_q, wrapping modulo NR_PORTS; rr_q when none.
    always_comb begin
        int   idx;
        logic found;
        winner = rr_q;
        found  = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NR_PORTS)
                idx = idx - NR_PORTS;
            if (!found && req_i[idx]) begin
                winner = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign cur_sel = (state_q == LOCKED) ? sel_q : winner;

    always_comb begin
        cache_addr_o  = addr_i[PLEN-1:0];
        cache_wdata_o = wdata_i[XLEN-1:0];
        cache_be_o    = be_i[XLEN/8-1:0];
        cache_size_o  = size_i[1:0];
        sel_req       = req_i[0];
        for (int k = 0; k < NR_PORTS; k++) begin
            if (int'(cur_sel) == k) begin
                cache_addr_o  = addr_i[k*PLEN +: PLEN];
                cache_wdata_o = wdata_i[k*XLEN +: XLEN];
                cache_be_o    = be_i[k*(XLEN/8) +: XLEN/8];
                cache_size_o  = size_i[k*2 +: 2];
                sel_req       = req_i[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        cache_req_o = 1'b0;
        gnt_o       = '0;
        unique case (state_q)
            IDLE: begin
                cache_req_o = (|req_i) && !stall_i;
                if (cache_req_o) begin
                    if (cache_gnt_i) begin
                        rr_d = next_ptr(winner);
                    end else begin
                        sel_d   = winner;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Other requesters and stall are ignored until this transfer ends.
                cache_req_o = sel_req;
                if (!sel_req) begin
                    state_d = IDLE;
                end else if (cache_gnt_i) begin
                    rr_d    = next_ptr(sel_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int k = 0; k < NR_PORTS; k++)
            gnt_o[k] = cache_req_o && cache_gnt_i && (int'(cur_sel) == k);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    assign sel_o  = cur_sel;
    assign busy_o = (state_q == LOCKED);
    assign idle_o = (state_q == IDLE) && (req_i == '0);

endmodule

// File: tb/tb_st_port_arbiter.sv
// Directed bench for st_port_arbiter: grant order, locking, kill, stall and reset-abort.
module tb_st_port_arbiter;

    localparam int NR_PORTS = 3;
    localparam int PLEN     = 56;
    localparam int XLEN     = 64;
    localparam int SEL_W    = 2;
    localparam logic [PLEN-1:0] ABASE = 56'h00_0000_0A00_0000;
    localparam logic [XLEN-1:0] DBASE = 64'h1111_2222_3333_0000;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       stall;
    logic [NR_PORTS-1:0]        req;
    logic [NR_PORTS*PLEN-1:0]   addr;
    logic [NR_PORTS*XLEN-1:0]   wdata;
    logic [NR_PORTS*XLEN/8-1:0] be;
    logic [NR_PORTS*2-1:0]      size;
    logic [NR_PORTS-1:0]        gnt;
    logic                       c_req;
    logic [PLEN-1:0]            c_addr;
    logic [XLEN-1:0]            c_wdata;
    logic [XLEN/8-1:0]          c_be;
    logic [1:0]                 c_size;
    logic                       c_gnt;
    logic [SEL_W-1:0]           sel;
    logic                       busy;
    logic                       idle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    st_port_arbiter #(.NR_PORTS(NR_PORTS), .PLEN(PLEN), .XLEN(XLEN), .SEL_W(SEL_W)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .size_i(size),
        .gnt_o(gnt), .cache_req_o(c_req), .cache_addr_o(c_addr),
        .cache_wdata_o(c_wdata), .cache_be_o(c_be), .cache_size_o(c_size),
        .cache_gnt_i(c_gnt), .sel_o(sel), .busy_o(busy), .idle_o(idle)
    );

    `define CHK(tag, obs, exp) \
        begin \
            n_chk++; \
            assert ((obs) === (exp)) else begin \
                n_fail++; \
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
            end \
        end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            n_chk++;
            if ((gnt & (gnt - 3'd1)) !== 3'b000) begin
                n_fail++;
                $error("FAIL gnt_onehot: observed %0b expected zero or one-hot", gnt);
            end
            if ((gnt !== 3'b000) && !(c_req && c_gnt)) begin
                n_fail++;
                $error("FAIL gnt_cond: observed gnt %0b req %0b cgnt %0b expected no grant", gnt, c_req, c_gnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [NR_PORTS-1:0] r, input logic g);
        stall = s;
        req   = r;
        c_gnt = g;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0);
        for (int k = 0; k < NR_PORTS; k++) begin
            addr[k*PLEN +: PLEN]     = ABASE + PLEN'(k);
            wdata[k*XLEN +: XLEN]    = DBASE + XLEN'(k);
            be[k*(XLEN/8) +: XLEN/8] = 8'h0F << k;
            size[k*2 +: 2]           = 2'(k);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        `CHK("rst_gnt", gnt, 3'b000)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_sel", sel, 2'd0)
        `CHK("rst_req", c_req, 1'b0)
        `CHK("rst_idle", idle, 1'b1)

        // All requesting, cache always granting: 0,1,2,0
        drive(1'b0, 3'b111, 1'b1);
        `CHK("rr_g0", gnt, 3'b001)
        `CHK("rr_addr0", c_addr, ABASE)
        tick();
        `CHK("rr_g1", gnt, 3'b010)
        `CHK("rr_wdata1", c_wdata, DBASE + 64'd1)
        tick();
        `CHK("rr_g2", gnt, 3'b100)
        `CHK("rr_size2", c_size, 2'd2)
        tick();
        `CHK("rr_wrap", gnt, 3'b001)
        tick();
        drive(1'b0, 3'b000, 1'b0);

        // Lock on port 1 for three cycles (rr=1)
        drive(1'b0, 3'b010, 1'b0);
        `CHK("lk_req", c_req, 1'b1)
        `CHK("lk_sel", sel, 2'd1)
        `CHK("lk_gnt0", gnt, 3'b000)
        `CHK("lk_busy0", busy, 1'b0)
        tick();
        drive(1'b0, 3'b011, 1'b0);
        `CHK("lk_busy2", busy, 1'b1)
        `CHK("lk_sel2", sel, 2'd1)
        `CHK("lk_addr2", c_addr, ABASE + 56'd1)
        `CHK("lk_gnt2", gnt, 3'b000)
        tick();
        `CHK("lk_busy3", busy, 1'b1)
        `CHK("lk_be3", c_be, 8'h1E)
        tick();
        drive(1'b0, 3'b011, 1'b1);
        `CHK("lk_busy4", busy, 1'b1)
        `CHK("lk_gnt4", gnt, 3'b010)
        tick();
        drive(1'b0, 3'b001, 1'b1);
        `CHK("lk_busy5", busy, 1'b0)
        `CHK("lk_gnt5", gnt, 3'b001)
        tick();
        drive(1'b0, 3'b000, 1'b0);

        // Lock on port 2 then kill (rr=1)
        drive(1'b0, 3'b100, 1'b0);
        `CHK("kill_sel", sel, 2'd2)
        tick();
        drive(1'b0, 3'b000, 1'b0);
        `CHK("kill_busy", busy, 1'b1)
        `CHK("kill_req", c_req, 1'b0)
        `CHK("kill_gnt", gnt, 3'b000)
        tick();
        `CHK("kill_idle", idle, 1'b1)
        drive(1'b0, 3'b101, 1'b1);
        `CHK("kill_rr", sel, 2'd2)
        `CHK("kill_gntnext", gnt, 3'b100)
        tick();
        drive(1'b0, 3'b000, 1'b0);

        // Stall in IDLE (rr=0)
        drive(1'b1, 3'b101, 1'b1);
        `CHK("st_req0", c_req, 1'b0)
        `CHK("st_gnt0", gnt, 3'b000)
        `CHK("st_idle0", idle, 1'b0)
        tick();
        `CHK("st_req1", c_req, 1'b0)
        `CHK("st_busy1", busy, 1'b0)
        drive(1'b0, 3'b101, 1'b1);
        `CHK("st_rel", gnt, 3'b001)
        tick();
        drive(1'b0, 3'b000, 1'b0);

        // Lock on port 0, stall while locked (rr=1)
        drive(1'b0, 3'b001, 1'b0);
        `CHK("sl_sel", sel, 2'd0)
        tick();
        drive(1'b1, 3'b001, 1'b0);
        `CHK("sl_req", c_req, 1'b1)
        `CHK("sl_busy", busy, 1'b1)
        tick();
        drive(1'b1, 3'b001, 1'b1);
        `CHK("sl_gnt", gnt, 3'b001)
        tick();
        `CHK("sl_after_req", c_req, 1'b0)
        `CHK("sl_after_gnt", gnt, 3'b000)
        `CHK("sl_after_idle", idle, 1'b0)
        tick();
        `CHK("sl_after2_req", c_req, 1'b0)
        drive(1'b0, 3'b001, 1'b1);
        `CHK("sl_rel", gnt, 3'b001)
        tick();
        drive(1'b0, 3'b000, 1'b0);
        `CHK("sl_idle", idle, 1'b1)

        // Reset while locked on port 1 (rr=1 before reset)
        drive(1'b0, 3'b010, 1'b0);
        tick();
        `CHK("ra_busy", busy, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("ra_gnt_rst", gnt, 3'b000)
        tick();
        rst = 1'b0;
        #1;
        `CHK("ra_busy0", busy, 1'b0)
        `CHK("ra_gnt", gnt, 3'b000)
        drive(1'b0, 3'b011, 1'b0);
        `CHK("ra_rr0", sel, 2'd0)
        tick();
        drive(1'b0, 3'b000, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
